// File: rtl/disp_pkg.sv
// Shared definitions for the locker display arbiter: digit codes, the
// arbiter state encoding, source encodings and digit clean-up helpers.
package disp_pkg;

  // Seven-segment digit codes understood by the display scanner
  localparam logic [3:0] NUM0  = 4'h0;
  localparam logic [3:0] NUM1  = 4'h1;
  localparam logic [3:0] NUM2  = 4'h2;
  localparam logic [3:0] NUM3  = 4'h3;
  localparam logic [3:0] NUM4  = 4'h4;
  localparam logic [3:0] NUM5  = 4'h5;
  localparam logic [3:0] NUM6  = 4'h6;
  localparam logic [3:0] NUM7  = 4'h7;
  localparam logic [3:0] NUM8  = 4'h8;
  localparam logic [3:0] NUM9  = 4'h9;
  localparam logic [3:0] NONE  = 4'hA;
  localparam logic [3:0] ERROR = 4'hB;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHOW_CODE = 2'd1,
    SHOW_ERR  = 2'd2
  } state_t;

  // Display owner reported on src
  localparam logic [1:0] SRC_KEY  = 2'd0;
  localparam logic [1:0] SRC_CODE = 2'd1;
  localparam logic [1:0] SRC_ERR  = 2'd2;

  // Codes the scanner cannot render are shown as blank
  function automatic logic [3:0] digit_clean(input logic [3:0] d);
    return (d > ERROR) ? NONE : d;
  endfunction

  function automatic logic [11:0] digits_clean(input logic [11:0] d);
    return {digit_clean(d[11:8]), digit_clean(d[7:4]), digit_clean(d[3:0])};
  endfunction

endpackage

// File: rtl/disp_hold_timer.sv
// Hold timer for timed display messages. Counts 0..HOLD_MS-1 from the
// last start pulse and then saturates; o_expire is high on the last count.
module disp_hold_timer #(
  parameter int HOLD_MS = 3000
) (
  input  logic clk_1k,
  input  logic rst,
  input  logic i_start,
  output logic o_expire
);

  localparam int             W    = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
  localparam logic [W-1:0]   LAST = W'(HOLD_MS - 1);

  logic [W-1:0] r_cnt;

  // Count up from a start pulse, holding at the last value instead of wrapping
  always_ff @(posedge clk_1k) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values; reset here is synchronous.
    if (rst || i_start) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/disp_arbiter.sv
// Display arbiter for the locker's 3-digit seven-segment display.
// Shares the digits between keypad entry, a timed pickup code and a timed
// error message. An error preempts a code; the preempted (or newly
// requested) code is replayed for a full hold period after the error.
// Optional build macro DISP_BLINK_EN: blink the error message with a
// half-period of BLINK_HALF cycles; otherwise the error is shown steadily.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int HOLD_MS    = 3000,
  parameter int BLINK_HALF = 250
) (
  input  logic        clk_1k,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [11:0] key_digits,
  input  logic        code_req,
  input  logic [11:0] code_digits,
  input  logic        err_req,
  input  logic [3:0]  err_code,
  output logic [3:0]  ds2,
  output logic [3:0]  ds1,
  output logic [3:0]  ds0,
  output logic [1:0]  src,
  output logic        done
);

  state_t      r_state, w_next;
  logic        w_start, w_expire, w_done;
  logic [11:0] r_code, w_code_nx;
  logic [3:0]  r_err, w_err_nx;
  logic        r_pend, w_pend_nx;
  logic [11:0] w_ds, r_ds;
  logic [1:0]  w_src, r_src;
  logic        r_done;

`ifdef DISP_BLINK_EN
  localparam int            BW     = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_HALF - 1);
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_on;
`else
  // BLINK_HALF has no effect in the steady-error build
  logic w_unused_blink;
  assign w_unused_blink = (BLINK_HALF != 0);
`endif

  disp_hold_timer #(.HOLD_MS(HOLD_MS)) u_hold (
    .clk_1k   (clk_1k),
    .rst      (rst),
    .i_start  (w_start),
    .o_expire (w_expire)
  );

  // State register
  always_ff @(posedge clk_1k) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state, latch updates, timer start and the display content for this state
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    w_next    = r_state;
    w_start   = 1'b0;
    w_done    = 1'b0;
    w_code_nx = r_code;
    w_err_nx  = r_err;
    w_pend_nx = r_pend;
    w_ds      = {NONE, NONE, NONE};
    w_src     = SRC_KEY;

    case (r_state)
      IDLE: begin
        if (key_valid) w_ds = digits_clean(key_digits);
        if (err_req) begin
          // Error wins a tie; a simultaneous code waits in the pending slot
          w_next   = SHOW_ERR;
          w_start  = 1'b1;
          w_err_nx = err_code;
          if (code_req) begin
            w_code_nx = code_digits;
            w_pend_nx = 1'b1;
          end
        end else if (code_req) begin
          w_next    = SHOW_CODE;
          w_start   = 1'b1;
          w_code_nx = code_digits;
        end
      end

      SHOW_CODE: begin
        w_ds  = digits_clean(r_code);
        w_src = SRC_CODE;
        if (err_req) begin
          // The code on screen (or a code arriving now) is replayed later
          w_next    = SHOW_ERR;
          w_start   = 1'b1;
          w_err_nx  = err_code;
          w_pend_nx = 1'b1;
          if (code_req) w_code_nx = code_digits;
        end else if (code_req) begin
          w_start   = 1'b1;
          w_code_nx = code_digits;
        end else if (w_expire) begin
          w_next  = IDLE;
          w_start = 1'b1;
          w_done  = 1'b1;
        end
      end

      SHOW_ERR: begin
        w_ds  = {ERROR, NONE, digit_clean(r_err)};
        w_src = SRC_ERR;
`ifdef DISP_BLINK_EN
        if (!r_blink_on) w_ds = {NONE, NONE, NONE};
`endif
        // The newest code request always replaces the pending one
        if (code_req) begin
          w_code_nx = code_digits;
          w_pend_nx = 1'b1;
        end
        if (err_req) begin
          w_start  = 1'b1;
          w_err_nx = err_code;
        end else if (w_expire) begin
          w_start   = 1'b1;
          w_done    = 1'b1;
          w_pend_nx = 1'b0;
          w_next    = (r_pend || code_req) ? SHOW_CODE : IDLE;
        end
      end

      default: w_next = IDLE;
    endcase
  end

  // Latched message contents and the pending-code flag
  always_ff @(posedge clk_1k) begin
    if (rst) begin
      r_code <= {NONE, NONE, NONE};
      r_err  <= NUM0;
      r_pend <= 1'b0;
    end else begin
      r_code <= w_code_nx;
      r_err  <= w_err_nx;
      r_pend <= w_pend_nx;
    end
  end

  // Registered outputs to the scanner and the control FSM
  always_ff @(posedge clk_1k) begin
    if (rst) begin
      r_ds   <= {NONE, NONE, NONE};
      r_src  <= SRC_KEY;
      r_done <= 1'b0;
    end else begin
      r_ds   <= w_ds;
      r_src  <= w_src;
      r_done <= w_done;
    end
  end

`ifdef DISP_BLINK_EN
  // Blink phase: restarts "on" whenever an error is entered or restarted
  always_ff @(posedge clk_1k) begin
    if (rst || (w_start && (w_next == SHOW_ERR))) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_blink_cnt == B_LAST) begin
      r_blink_cnt <= '0;
      r_blink_on  <= ~r_blink_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end
`endif

  assign ds2  = r_ds[11:8];
  assign ds1  = r_ds[7:4];
  assign ds0  = r_ds[3:0];
  assign src  = r_src;
  assign done = r_done;

endmodule

// File: doc/disp_arbiter.md
# disp_arbiter

Arbiter and sequencer for the locker's 3-digit seven-segment display.
- Shares the display between three sources: live keypad entry, a timed pickup-code message and a timed error message.
- Drives the 4-bit digit codes consumed by the display scanner.
- Runs on the 1 kHz scan clock and sits between the locker control FSM and the display scanner.

## Interface
Parameters:
- HOLD_MS, 3000: cycles a timed message stays on the display (1 ms per cycle).
- BLINK_HALF, 250: half-period of the error blink, in cycles; used only with blink compiled in.

Ports:
- clk_1k  in  1  1 kHz system clock.
- rst  in  1  reset, synchronous, active-high.
- key_valid  in  1  level; keypad entry is active.
- key_digits  in  12  {d2,d1,d0} keypad codes.
- code_req  in  1  one-cycle pulse; show code_digits.
- code_digits  in  12  {d2,d1,d0} pickup-code codes, sampled with code_req.
- err_req  in  1  one-cycle pulse; show an error.
- err_code  in  4  error number 0–9, sampled with err_req.
- ds2, ds1, ds0  out  4 each  digit codes to the scanner.
- src  out  2  current owner: 0 = idle/keypad, 1 = code, 2 = error.
- done  out  1  one-cycle pulse when a timed message expires normally.

## Operation
- Digit codes: 0–9 are numerals, 4'hA is blank, 4'hB is "E".
- Any incoming nibble above 4'hB is displayed as blank.
- States are IDLE, SHOW_CODE and SHOW_ERR. A hold timer counts 0..HOLD_MS-1 and clears on every state entry.
- IDLE:
  - Display shows key_digits if key_valid, otherwise "blank blank blank".
  - code_req latches code_digits and moves to SHOW_CODE.
  - err_req latches err_code and moves to SHOW_ERR.
- SHOW_CODE:
  - Display shows the latched code.
  - A new code_req relatches the code and restarts the timer.
  - err_req preempts to SHOW_ERR; the current code goes to pending and is later replayed for a full HOLD_MS.
  - Timer expiry returns to IDLE and pulses done.
- SHOW_ERR:
  - Display shows "E", blank, err_code.
  - A new err_req relatches err_code and restarts the timer.
  - code_req latches code_digits into the pending slot; the newest request overwrites it.
  - Timer expiry goes to SHOW_CODE (timer restarted) if pending is set, otherwise to IDLE. Either way done pulses and pending clears.
- Simultaneous err_req and code_req: the error wins and the code becomes pending.
- key_digits never preempt a timed message and are not latched.
- done does not pulse on preemption or on a restart.
- Reset mid-message: the message is abandoned, pending is cleared and no done pulse is produced.
- Reset values:
  - state = IDLE, timer = 0, pending = 0.
  - ds2 = ds1 = ds0 = 4'hA, src = 0, done = 0.

## Timing
- A request is sampled at edge N and the state changes at edge N.
- ds/src are registered from the state and show the new content from edge N+1.
- A message is visible for exactly HOLD_MS cycles unless it is preempted or restarted.
- Expiry is detected when the timer equals HOLD_MS-1. The state changes at the next edge, and done is high for the cycle following that edge.
- In IDLE, key_digits changes reach ds with one cycle of latency.
- Timer width is clog2(HOLD_MS). The timer saturates and never wraps.

## Configuration
- DISP_BLINK_EN defined:
  - In SHOW_ERR all three digits blink. Each half-period is BLINK_HALF cycles: the on-phase shows "E", blank, err_code and the off-phase shows "blank blank blank".
  - The phase starts "on" at every SHOW_ERR entry or restart.
  - The blink phase has no effect on the hold timer or on done.
- DISP_BLINK_EN undefined: the error shows steadily. No blink counter is synthesized and BLINK_HALF is ignored.

## Structure
- Shared package disp_pkg holds:
  - digit-code constants NUM0..NUM9, NONE = 4'hA, ERROR = 4'hB;
  - the state enum IDLE/SHOW_CODE/SHOW_ERR;
  - src encodings SRC_KEY/SRC_CODE/SRC_ERR.
- Sub-module disp_hold_timer: a parameterized counter with start (clear) and expire outputs.

## Test plan
Simulation uses HOLD_MS=8, BLINK_HALF=2.
- Reset, then key_valid=1 with key_digits=12'h123 → ds2/ds1/ds0 = 1/2/3 one cycle later, src=0. key_valid=0 → A/A/A.
- code_req with 12'h456 → 4/5/6 for exactly 8 cycles, src=1, then done for 1 cycle, then back to the keypad digits.
- During the code at cycle 3, err_req with err_code=7 → B/A/7 for 8 cycles, done, then 4/5/6 for a full 8 cycles, done, then IDLE.
- Same-cycle err_req(2) and code_req(12'h999) → B/A/2 for 8 cycles, then 9/9/9 for 8 cycles; two done pulses total.
- Reset asserted mid-SHOW_ERR with a code pending → next cycle A/A/A, src=0, no done, and the pending code is never shown.
- With DISP_BLINK_EN, err_req(5) → B/A/5 for 2 cycles, A/A/A for 2 cycles, repeating. done occurs 8 cycles after entry.
